// File: rtl/dep_rule_cfg_loader.sv
// Deparser type-rule config loader: assembles one type rule in shadow registers from
// 32-bit register writes, then commits it to one slot or walks a clear over all slots.
module dep_rule_cfg_loader #(
    parameter int unsigned RULE_NUM          = 8,
    parameter int unsigned TYPE_NUM          = 4,
    parameter int unsigned TYPE_WIDTH        = 16,
    parameter int unsigned TYPE_OFFSET_WIDTH = 8,
    parameter int unsigned KEY_FILED_NUM     = 8,
    parameter int unsigned KEY_OFFSET_WIDTH  = 6,
    parameter int unsigned HEAD_SHIFT_WIDTH  = 7,
    parameter int unsigned META_SHIFT_WIDTH  = 7
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic                                            i_cfg_valid,
    output logic                                            o_cfg_ready,
    input  logic [7:0]                                      i_cfg_addr,
    input  logic [31:0]                                     i_cfg_data,
    output logic                                            o_cfg_err,
    output logic [15:0]                                     o_commit_cnt,
    output logic [RULE_NUM-1:0]                             o_rule_wren,
    output logic                                            o_typeRule_valid,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                  o_typeRule_typeData,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                  o_typeRule_typeMask,
    output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]           o_typeRule_typeOffset,
    output logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0]   o_typeRule_keyOffset,
    output logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]       o_typeRule_keyReplaceOffset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                     o_typeRule_headShift,
    output logic [META_SHIFT_WIDTH-1:0]                     o_typeRule_metaShift
);

    localparam int unsigned CNT_W = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
    localparam int unsigned KOW   = KEY_OFFSET_WIDTH + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_CLEAR  = 2'd2;

    localparam logic [RULE_NUM-1:0] WREN_SLOT0 = RULE_NUM'(1);

    logic [1:0]                                         state_q, state_d;
    logic                                               cfg_ready_q, cfg_ready_d;
    logic                                               cfg_err_q, cfg_err_d;
    logic [15:0]                                        commit_cnt_q, commit_cnt_d;
    logic [RULE_NUM-1:0]                                rule_wren_q, rule_wren_d;
    logic [CNT_W-1:0]                                   clr_cnt_q, clr_cnt_d;

    logic                                               valid_q, valid_d;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                type_data_q, type_data_d;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                type_mask_q, type_mask_d;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]         type_off_q, type_off_d;
    logic [KEY_FILED_NUM-1:0][KOW-1:0]                  key_off_q, key_off_d;
    logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0]     key_rep_q, key_rep_d;
    logic [HEAD_SHIFT_WIDTH-1:0]                        head_shift_q, head_shift_d;
    logic [META_SHIFT_WIDTH-1:0]                        meta_shift_q, meta_shift_d;

    logic                                               accept_c;
    logic                                               addr_hit_c;
    logic                                               cmd_commit_c;
    logic                                               cmd_clear_c;
    logic                                               idx_ok_c;
    logic [3:0]                                         addr_idx_c;
    logic                                               unused_data_c;

    assign accept_c      = i_cfg_valid & cfg_ready_q;
    assign addr_idx_c    = i_cfg_addr[3:0];
    assign idx_ok_c      = ({1'b0, i_cfg_data[7:0]} < 9'(RULE_NUM));
    assign unused_data_c = ^i_cfg_data;

    // Address decode and shadow register writes
    always_comb begin
        valid_d      = valid_q;
        type_data_d  = type_data_q;
        type_mask_d  = type_mask_q;
        type_off_d   = type_off_q;
        key_off_d    = key_off_q;
        key_rep_d    = key_rep_q;
        head_shift_d = head_shift_q;
        meta_shift_d = meta_shift_q;
        addr_hit_c   = 1'b0;
        cmd_commit_c = 1'b0;
        cmd_clear_c  = 1'b0;

        case (i_cfg_addr[7:4])
            4'h0: begin
                for (int unsigned j = 0; j < TYPE_NUM; j++) begin
                    if (addr_idx_c == 4'(j)) begin
                        addr_hit_c = 1'b1;
                        if (accept_c) type_data_d[j] = i_cfg_data[TYPE_WIDTH-1:0];
                    end
                end
            end
            4'h1: begin
                for (int unsigned j = 0; j < TYPE_NUM; j++) begin
                    if (addr_idx_c == 4'(j)) begin
                        addr_hit_c = 1'b1;
                        if (accept_c) type_mask_d[j] = i_cfg_data[TYPE_WIDTH-1:0];
                    end
                end
            end
            4'h2: begin
                for (int unsigned j = 0; j < TYPE_NUM; j++) begin
                    if (addr_idx_c == 4'(j)) begin
                        addr_hit_c = 1'b1;
                        if (accept_c) type_off_d[j] = i_cfg_data[TYPE_OFFSET_WIDTH-1:0];
                    end
                end
            end
            4'h3: begin
                for (int unsigned k = 0; k < KEY_FILED_NUM; k++) begin
                    if (addr_idx_c == 4'(k)) begin
                        addr_hit_c = 1'b1;
                        if (accept_c) begin
                            key_off_d[k] = i_cfg_data[KEY_OFFSET_WIDTH:0];
                            key_rep_d[k] = i_cfg_data[16 +: KEY_OFFSET_WIDTH];
                        end
                    end
                end
            end
            4'h4: begin
                if (addr_idx_c == 4'h0) begin
                    addr_hit_c = 1'b1;
                    if (accept_c) head_shift_d = i_cfg_data[HEAD_SHIFT_WIDTH-1:0];
                end else if (addr_idx_c == 4'h1) begin
                    addr_hit_c = 1'b1;
                    if (accept_c) meta_shift_d = i_cfg_data[META_SHIFT_WIDTH-1:0];
                end
            end
            4'h5: begin
                if (addr_idx_c == 4'h0) begin
                    addr_hit_c = 1'b1;
                    if (accept_c) valid_d = i_cfg_data[0];
                end
            end
            4'h6: begin
                if (addr_idx_c == 4'h0) begin
                    addr_hit_c   = 1'b1;
                    cmd_commit_c = 1'b1;
                end else if (addr_idx_c == 4'h1) begin
                    addr_hit_c  = 1'b1;
                    cmd_clear_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control FSM: commit pulse, clear walk, ready/err/count generation
    always_comb begin
        state_d      = state_q;
        rule_wren_d  = rule_wren_q;
        clr_cnt_d    = clr_cnt_q;
        commit_cnt_d = commit_cnt_q;
        cfg_err_d    = accept_c & (~addr_hit_c | (cmd_commit_c & ~idx_ok_c));

        unique case (state_q)
            S_IDLE: begin
                if (accept_c && cmd_commit_c && idx_ok_c) begin
                    state_d     = S_COMMIT;
                    rule_wren_d = WREN_SLOT0 << i_cfg_data[7:0];
                end else if (accept_c && cmd_clear_c) begin
                    state_d     = S_CLEAR;
                    clr_cnt_d   = '0;
                    rule_wren_d = WREN_SLOT0;
                end
            end
            S_COMMIT: begin
                state_d      = S_IDLE;
                rule_wren_d  = '0;
                commit_cnt_d = commit_cnt_q + 16'd1;
            end
            S_CLEAR: begin
                if (clr_cnt_q == CNT_W'(RULE_NUM - 1)) begin
                    state_d     = S_IDLE;
                    rule_wren_d = '0;
                end else begin
                    clr_cnt_d   = clr_cnt_q + CNT_W'(1);
                    rule_wren_d = rule_wren_q << 1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rule_wren_d = '0;
            end
        endcase

        cfg_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cfg_ready_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            commit_cnt_q <= '0;
            rule_wren_q  <= '0;
            clr_cnt_q    <= '0;
            valid_q      <= 1'b0;
            type_data_q  <= '0;
            type_mask_q  <= '0;
            type_off_q   <= '0;
            key_off_q    <= '0;
            key_rep_q    <= '0;
            head_shift_q <= '0;
            meta_shift_q <= '0;
        end else begin
            state_q      <= state_d;
            cfg_ready_q  <= cfg_ready_d;
            cfg_err_q    <= cfg_err_d;
            commit_cnt_q <= commit_cnt_d;
            rule_wren_q  <= rule_wren_d;
            clr_cnt_q    <= clr_cnt_d;
            valid_q      <= valid_d;
            type_data_q  <= type_data_d;
            type_mask_q  <= type_mask_d;
            type_off_q   <= type_off_d;
            key_off_q    <= key_off_d;
            key_rep_q    <= key_rep_d;
            head_shift_q <= head_shift_d;
            meta_shift_q <= meta_shift_d;
        end
    end

    assign o_cfg_ready                 = cfg_ready_q;
    assign o_cfg_err                   = cfg_err_q;
    assign o_commit_cnt                = commit_cnt_q;
    assign o_rule_wren                 = rule_wren_q;
    // Downstream must never capture a valid rule while slots are being invalidated
    assign o_typeRule_valid            = valid_q & (state_q != S_CLEAR);
    assign o_typeRule_typeData         = type_data_q;
    assign o_typeRule_typeMask         = type_mask_q;
    assign o_typeRule_typeOffset       = type_off_q;
    assign o_typeRule_keyOffset        = key_off_q;
    assign o_typeRule_keyReplaceOffset = key_rep_q;
    assign o_typeRule_headShift        = head_shift_q;
    assign o_typeRule_metaShift        = meta_shift_q;

endmodule

// File: tb/tb_dep_rule_cfg_loader.sv
// Directed self-checking bench for dep_rule_cfg_loader with default parameters.
module tb_dep_rule_cfg_loader;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_err;
    logic [15:0] commit_cnt;
    logic [7:0]  rule_wren;
    logic        rule_valid;
    logic [63:0] type_data;
    logic [63:0] type_mask;
    logic [31:0] type_off;
    logic [55:0] key_off;
    logic [47:0] key_rep;
    logic [6:0]  head_shift;
    logic [6:0]  meta_shift;

    int n_cmp;
    int n_err;

    dep_rule_cfg_loader dut (
        .i_clk                       (clk),
        .i_rst_n                     (rst_n),
        .i_cfg_valid                 (cfg_valid),
        .o_cfg_ready                 (cfg_ready),
        .i_cfg_addr                  (cfg_addr),
        .i_cfg_data                  (cfg_data),
        .o_cfg_err                   (cfg_err),
        .o_commit_cnt                (commit_cnt),
        .o_rule_wren                 (rule_wren),
        .o_typeRule_valid            (rule_valid),
        .o_typeRule_typeData         (type_data),
        .o_typeRule_typeMask         (type_mask),
        .o_typeRule_typeOffset       (type_off),
        .o_typeRule_keyOffset        (key_off),
        .o_typeRule_keyReplaceOffset (key_rep),
        .o_typeRule_headShift        (head_shift),
        .o_typeRule_metaShift        (meta_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;

        // Reset state
        step();
        step();
        check("rst_ready", 64'(cfg_ready), 64'd0);
        check("rst_wren", 64'(rule_wren), 64'd0);
        check("rst_err", 64'(cfg_err), 64'd0);
        check("rst_cnt", 64'(commit_cnt), 64'd0);
        check("rst_tdata", type_data, 64'd0);
        check("rst_valid", 64'(rule_valid), 64'd0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 64'(cfg_ready), 64'd1);

        // Build a rule and commit it to slot 3
        wr(8'h00, 32'h0000_0800);
        wr(8'h10, 32'h0000_FFFF);
        wr(8'h32, 32'h0005_0045);
        wr(8'h23, 32'h0000_00AB);
        wr(8'h40, 32'h0000_01A5);
        wr(8'h41, 32'h0000_0013);
        wr(8'h50, 32'h0000_0001);
        check("ready_shadow_wr", 64'(cfg_ready), 64'd1);
        wr(8'h60, 32'h0000_0003);
        check("c3_wren", 64'(rule_wren), 64'h08);
        check("c3_ready", 64'(cfg_ready), 64'd0);
        check("c3_tdata", type_data, 64'h0000_0000_0000_0800);
        check("c3_tmask", type_mask, 64'h0000_0000_0000_FFFF);
        check("c3_toff", 64'(type_off), 64'hAB00_0000);
        check("c3_koff", 64'(key_off), 64'h45 << 14);
        check("c3_krep", 64'(key_rep), 64'h5 << 12);
        check("c3_head", 64'(head_shift), 64'h25);
        check("c3_meta", 64'(meta_shift), 64'h13);
        check("c3_valid", 64'(rule_valid), 64'd1);
        check("c3_err", 64'(cfg_err), 64'd0);
        step();
        check("c3_wren_off", 64'(rule_wren), 64'd0);
        check("c3_ready_back", 64'(cfg_ready), 64'd1);
        check("c3_cnt", 64'(commit_cnt), 64'd1);

        // Clear-all walk over 8 slots
        wr(8'h61, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clr_wren%0d", i), 64'(rule_wren), 64'd1 << i);
            check($sformatf("clr_valid%0d", i), 64'(rule_valid), 64'd0);
            check($sformatf("clr_ready%0d", i), 64'(cfg_ready), 64'd0);
            step();
        end
        check("clr_wren_end", 64'(rule_wren), 64'd0);
        check("clr_ready_end", 64'(cfg_ready), 64'd1);
        check("clr_valid_end", 64'(rule_valid), 64'd1);
        check("clr_cnt", 64'(commit_cnt), 64'd1);

        // Bad commit index and unmapped addresses
        wr(8'h60, 32'h0000_0009);
        check("bad_idx_err", 64'(cfg_err), 64'd1);
        check("bad_idx_wren", 64'(rule_wren), 64'd0);
        check("bad_idx_ready", 64'(cfg_ready), 64'd1);
        step();
        check("bad_idx_err_off", 64'(cfg_err), 64'd0);
        wr(8'h77, 32'h0000_DEAD);
        check("unmap_err", 64'(cfg_err), 64'd1);
        check("unmap_wren", 64'(rule_wren), 64'd0);
        step();
        check("unmap_err_off", 64'(cfg_err), 64'd0);
        wr(8'h04, 32'h0000_1234);
        check("oob_type_err", 64'(cfg_err), 64'd1);
        check("oob_type_tdata", type_data, 64'h0000_0000_0000_0800);
        wr(8'h03, 32'h0000_ABCD);
        check("top_type_err", 64'(cfg_err), 64'd0);
        check("top_type_tdata", type_data, 64'hABCD_0000_0000_0800);
        check("bad_cnt", 64'(commit_cnt), 64'd1);

        // Back-to-back commits with valid held high
        cfg_valid = 1'b1;
        cfg_addr  = 8'h60;
        cfg_data  = 32'h0;
        step();
        check("b2b0_wren", 64'(rule_wren), 64'h01);
        check("b2b0_ready", 64'(cfg_ready), 64'd0);
        cfg_data = 32'h1;
        step();
        check("b2b0_wren_off", 64'(rule_wren), 64'd0);
        check("b2b0_ready_back", 64'(cfg_ready), 64'd1);
        check("b2b0_cnt", 64'(commit_cnt), 64'd2);
        step();
        cfg_valid = 1'b0;
        check("b2b1_wren", 64'(rule_wren), 64'h02);
        check("b2b1_ready", 64'(cfg_ready), 64'd0);
        step();
        check("b2b1_wren_off", 64'(rule_wren), 64'd0);
        check("b2b1_cnt", 64'(commit_cnt), 64'd3);

        // Reset asserted in the fourth cycle of a clear
        wr(8'h61, 32'h0);
        step();
        step();
        step();
        check("rclr_wren_pre", 64'(rule_wren), 64'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check("rclr_wren_async", 64'(rule_wren), 64'd0);
        check("rclr_ready_async", 64'(cfg_ready), 64'd0);
        check("rclr_cnt_async", 64'(commit_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("rclr_idle_wren%0d", i), 64'(rule_wren), 64'd0);
        end
        check("rclr_ready", 64'(cfg_ready), 64'd1);
        check("rclr_tdata", type_data, 64'd0);
        check("rclr_valid", 64'(rule_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dep_rule_cfg_loader.md
# dep_rule_cfg_loader

Configuration front-end for the deparser type-lookup stage. It accepts 32-bit register writes from the control path and assembles one type rule in shadow registers. On a commit write it drives a one-cycle one-hot rule write-enable, with the shadow rule held stable on the rule-data outputs. It also supports a multi-cycle "clear all rules" sequence that invalidates every rule slot, one slot per cycle.

## Interface
Parameters:
- RULE_NUM, 8, number of rule slots in the downstream lookup (≤ 256)
- TYPE_NUM, 4, type fields per rule
- TYPE_WIDTH, 16, width of one type field (≤ 32)
- TYPE_OFFSET_WIDTH, 8, width of one type offset
- KEY_FILED_NUM, 8, key fields per rule (≤ 16)
- KEY_OFFSET_WIDTH, 6, key offset width; the key offset carries an extra top valid bit
- HEAD_SHIFT_WIDTH, 7, head shift width
- META_SHIFT_WIDTH, 7, meta shift width

Ports:
- i_clk  in  1  the block's single clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_cfg_valid  in  1  config write request
- o_cfg_ready  out  1  config write accept; registered
- i_cfg_addr  in  8  config register address
- i_cfg_data  in  32  config write data
- o_cfg_err  out  1  one-cycle pulse on an unmapped address or a bad commit index
- o_commit_cnt  out  16  count of successful commits; wraps
- o_rule_wren  out  RULE_NUM  one-hot rule write-enable; registered
- o_typeRule_valid  out  1  rule valid bit
- o_typeRule_typeData  out  TYPE_NUM×TYPE_WIDTH  rule type data
- o_typeRule_typeMask  out  TYPE_NUM×TYPE_WIDTH  rule type mask
- o_typeRule_typeOffset  out  TYPE_NUM×TYPE_OFFSET_WIDTH  rule type offsets
- o_typeRule_keyOffset  out  KEY_FILED_NUM×(KEY_OFFSET_WIDTH+1)  key offsets; top bit is the valid bit
- o_typeRule_keyReplaceOffset  out  KEY_FILED_NUM×KEY_OFFSET_WIDTH  replace-slot index per key field
- o_typeRule_headShift  out  HEAD_SHIFT_WIDTH  head shift
- o_typeRule_metaShift  out  META_SHIFT_WIDTH  meta shift

## Operation
- A write is accepted at a rising edge where i_cfg_valid & o_cfg_ready. The shadow register it targets updates at that same edge. The low bits of i_cfg_data are used; the rest are ignored.
- Address map (j < TYPE_NUM, k < KEY_FILED_NUM):
  - 0x00+j: typeData[j]
  - 0x10+j: typeMask[j]
  - 0x20+j: typeOffset[j]
  - 0x30+k: keyOffset[k] = data[KEY_OFFSET_WIDTH:0], and keyReplaceOffset[k] = data[16 +: KEY_OFFSET_WIDTH]
  - 0x40: headShift
  - 0x41: metaShift
  - 0x50: valid = data[0]
  - 0x60: COMMIT, rule index = data[7:0]
  - 0x61: CLEAR_ALL
- Any other address, including j ≥ TYPE_NUM or k ≥ KEY_FILED_NUM inside a range, is accepted, has no effect, and pulses o_cfg_err.
- The o_typeRule_* outputs are the shadow registers driven directly. The one exception is o_typeRule_valid, which is forced to 0 during CLEAR.
- FSM states: IDLE, COMMIT, CLEAR.
  - IDLE → COMMIT: COMMIT accepted with index < RULE_NUM. o_rule_wren ← 1<<index.
  - IDLE stays in IDLE: COMMIT accepted with index ≥ RULE_NUM. o_cfg_err pulses; no wren.
  - COMMIT → IDLE: after one cycle. o_rule_wren ← 0; o_commit_cnt ← o_commit_cnt + 1 (wraps at 16 bits).
  - IDLE → CLEAR: CLEAR_ALL accepted. Slot counter ← 0; o_rule_wren ← 1<<0.
  - CLEAR: each cycle, o_rule_wren ← 1<<(counter+1). After slot RULE_NUM-1, go to IDLE with o_rule_wren ← 0.
- Shadow registers are not cleared by COMMIT or CLEAR. Back-to-back commits of the same shadow to different slots are legal.

## Timing
- Reset (async assert) clears everything: state IDLE, all shadow registers, o_rule_wren, o_cfg_err, o_commit_cnt and o_cfg_ready all 0. Reset mid-COMMIT or mid-CLEAR aborts immediately; o_rule_wren drops to 0 asynchronously.
- o_cfg_ready rises at the first clock edge after reset release. It is 1 only in IDLE and is registered. It falls at the edge that accepts a COMMIT (valid index) or a CLEAR_ALL.
- Commit accepted at edge T:
  - Cycle T..T+1: o_rule_wren is one-hot and the shadow is stable on the outputs.
  - Edge T+1: the lookup captures the rule.
  - o_cfg_ready returns high after edge T+1, so the next write can be accepted at edge T+2.
- CLEAR_ALL accepted at edge T: o_rule_wren = 1<<i during cycle T+i..T+i+1, for i = 0..RULE_NUM-1. o_cfg_ready is high again after edge T+RULE_NUM.
- o_cfg_err is high for exactly the cycle following the offending accept edge.
- Shadow writes take effect at the accept edge, so a shadow write immediately before a COMMIT is included in that commit.

## Test plan
- After reset: all outputs 0; o_cfg_ready=1 on the first cycle after release.
- Write typeData[0]=0x0800, typeMask[0]=0xFFFF, keyOffset[2]=0x00050045, valid=1, then COMMIT 3 → o_rule_wren=0x08 for exactly one cycle, with typeData[0]=0x0800, keyOffset[2]=0x45 (valid bit set, offset 5), keyReplaceOffset[2]=5, valid=1; o_commit_cnt=1; o_cfg_ready low for exactly 1 cycle.
- CLEAR_ALL with RULE_NUM=8 → o_rule_wren walks 0x01..0x80 over 8 consecutive cycles with o_typeRule_valid=0; o_cfg_ready low for 8 cycles; o_commit_cnt unchanged.
- COMMIT index 9, then a write to address 0x77 → two o_cfg_err pulses; no o_rule_wren activity; shadow unchanged.
- i_cfg_valid held high with back-to-back COMMIT 0 and COMMIT 1 → accepts 2 cycles apart; wren 0x01 then 0x02, each for one cycle; o_commit_cnt=2.
- Assert i_rst_n low during cycle 4 of a CLEAR → o_rule_wren=0 immediately; after release the state is IDLE and no further wren pulses occur.
